// File: rtl/seg7_scan_capture.sv
// Receive side of the 4-digit multiplexed 7-segment driver: filters the scanned
// digit/segment lines, decodes each stable digit to BCD and assembles full frames.
module seg7_scan_capture #(
    parameter int STABLE_CYCLES = 16,
    parameter int FRAME_TIMEOUT = 262143
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  digit_i,
    input  logic [6:0]  segment_i,
    output logic [15:0] bcd_o,
    output logic        value_valid_o,
    output logic        digit_err_o,
    output logic        timeout_o
);
    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W  = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(FRAME_TIMEOUT);

    // Returns {decodable, bcd} for an active-low segment pattern.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg_n);
        logic [6:0] seg;
        seg = ~seg_n;
        case (seg)
            7'h7E:   decode_seg = {1'b1, 4'd0};
            7'h30:   decode_seg = {1'b1, 4'd1};
            7'h6D:   decode_seg = {1'b1, 4'd2};
            7'h79:   decode_seg = {1'b1, 4'd3};
            7'h33:   decode_seg = {1'b1, 4'd4};
            7'h5B:   decode_seg = {1'b1, 4'd5};
            7'h5F:   decode_seg = {1'b1, 4'd6};
            7'h70:   decode_seg = {1'b1, 4'd7};
            7'h7F:   decode_seg = {1'b1, 4'd8};
            7'h7B:   decode_seg = {1'b1, 4'd9};
            default: decode_seg = {1'b0, 4'd0};
        endcase
    endfunction

    logic [3:0]       s_digit_q, s_digit_d;
    logic [6:0]       s_seg_q, s_seg_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             accept_q, accept_d;
    logic [3:0]       seen_q, seen_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    logic             timeout_q, timeout_d;

    logic [4:0] decoded;
    logic [3:0] digit_n;
    logic [3:0] hit;
    logic [3:0] seen_new;

    always_comb begin
        s_digit_d = digit_i;
        s_seg_d   = segment_i;
        run_d     = run_q;
        seen_d    = seen_q;
        shadow_d  = shadow_q;
        bcd_d     = bcd_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        tcnt_d    = tcnt_q;
        hit       = 4'b0000;
        seen_new  = seen_q;
        decoded   = decode_seg(s_seg_q);
        digit_n   = ~s_digit_q;

        if ({digit_i, segment_i} != {s_digit_q, s_seg_q}) begin
            run_d = {{(RUN_W-1){1'b0}}, 1'b1};
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + 1'b1;
        end
        // The accept fires one cycle after the run saturates, so it acts on s as it stands.
        accept_d = (run_d == RUN_MAX) && (run_q != RUN_MAX);

        if (accept_q && (s_digit_q != 4'b1111)) begin
            case (digit_n)
                4'b1000: begin shadow_d[3:0]   = decoded[3:0]; hit = 4'b0001; end
                4'b0100: begin shadow_d[7:4]   = decoded[3:0]; hit = 4'b0010; end
                4'b0010: begin shadow_d[11:8]  = decoded[3:0]; hit = 4'b0100; end
                4'b0001: begin shadow_d[15:12] = decoded[3:0]; hit = 4'b1000; end
                default: hit = 4'b0000;
            endcase
            if ((hit == 4'b0000) || !decoded[4]) begin
                err_d    = 1'b1;
                shadow_d = shadow_q;
            end else begin
                seen_new = seen_q | hit;
                if (seen_new == 4'b1111) begin
                    bcd_d   = shadow_d;
                    valid_d = 1'b1;
                    seen_d  = 4'b0000;
                end else begin
                    seen_d = seen_new;
                end
            end
        end

        // A completed frame wins over a timeout landing on the same cycle.
        if (valid_d) begin
            tcnt_d = '0;
        end else if (tcnt_q != TO_MAX) begin
            tcnt_d = tcnt_q + 1'b1;
        end
        timeout_d = (tcnt_d == TO_MAX) && !valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_digit_q <= 4'b1111;
            s_seg_q   <= 7'h7F;
            run_q     <= '0;
            accept_q  <= 1'b0;
            seen_q    <= 4'b0000;
            shadow_q  <= 16'h0000;
            bcd_q     <= 16'h0000;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            s_digit_q <= s_digit_d;
            s_seg_q   <= s_seg_d;
            run_q     <= run_d;
            accept_q  <= accept_d;
            seen_q    <= seen_d;
            shadow_q  <= shadow_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bcd_o         = bcd_q;
    assign value_valid_o = valid_q;
    assign digit_err_o   = err_q;
    assign timeout_o     = timeout_q;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with STABLE_CYCLES=4, FRAME_TIMEOUT=100.
module tb_seg7_scan_capture;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  digit_i = 4'b1111;
    logic [6:0]  segment_i = 7'h7F;
    logic [15:0] bcd_o;
    logic        value_valid_o;
    logic        digit_err_o;
    logic        timeout_o;

    seg7_scan_capture #(.STABLE_CYCLES(4), .FRAME_TIMEOUT(100)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .digit_i(digit_i), .segment_i(segment_i),
        .bcd_o(bcd_o), .value_valid_o(value_valid_o), .digit_err_o(digit_err_o),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    int vcnt = 0;
    int ecnt = 0;

    // Pulse counters, sampled 1 time unit after each rising edge.
    always @(posedge clk_i) begin
        #1;
        if (value_valid_o) vcnt++;
        if (digit_err_o) ecnt++;
    end

    // Active-low segment codes for digits 0..9
    localparam logic [6:0] S0 = 7'h01, S1 = 7'h4F, S2 = 7'h12, S3 = 7'h06, S4 = 7'h4C;
    localparam logic [6:0] S5 = 7'h24, S6 = 7'h20, S7 = 7'h0F, S9 = 7'h04;
    localparam logic [3:0] DU = 4'b0111, DT = 4'b1011, DH = 4'b1101, DK = 4'b1110;

    typedef struct {
        logic [3:0]  dig;
        logic [6:0]  seg;
        int          n;
        int          ev;
        int          ee;
        logic [15:0] eb;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
        digit_i = d;
        segment_i = s;
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk_i);
        chk("reset_bcd", 32'(bcd_o), 32'h0);
        chk("reset_valid", 32'(value_valid_o), 32'h0);
        chk("reset_err", 32'(digit_err_o), 32'h0);
        chk("reset_timeout", 32'(timeout_o), 32'h0);
        rst_i = 1'b0;

        // Timeout with blank inputs: rises on the 100th cycle after reset
        repeat (99) @(negedge clk_i);
        chk("timeout_before", 32'(timeout_o), 32'h0);
        @(negedge clk_i);
        chk("timeout_rise", 32'(timeout_o), 32'h1);
        repeat (20) @(negedge clk_i);
        chk("timeout_hold", 32'(timeout_o), 32'h1);

        // Basic frame and pulse latency after the thousands digit
        vcnt = 0; ecnt = 0;
        hold(DU, S7, 8);
        hold(DT, S3, 8);
        hold(DH, S0, 8);
        hold(DK, S1, 4);
        chk("lat_valid_early", 32'(value_valid_o), 32'h0);
        chk("lat_timeout_still", 32'(timeout_o), 32'h1);
        @(negedge clk_i);
        chk("lat_valid", 32'(value_valid_o), 32'h1);
        chk("lat_bcd", 32'(bcd_o), 32'h1037);
        chk("lat_timeout_clear", 32'(timeout_o), 32'h0);
        @(negedge clk_i);
        chk("lat_valid_single", 32'(value_valid_o), 32'h0);
        repeat (2) @(negedge clk_i);
        chk("lat_vcnt", 32'(vcnt), 32'd1);
        chk("lat_ecnt", 32'(ecnt), 32'd0);

        // Table: short run, overwrite, error cases, blank, and seen-mask integrity
        tbl[0]  = '{DU, S5, 3, 0, 0, 16'h1037};
        tbl[1]  = '{DU, S6, 8, 0, 0, 16'h1037};
        tbl[2]  = '{DT, S1, 8, 0, 0, 16'h1037};
        tbl[3]  = '{DH, S2, 8, 0, 0, 16'h1037};
        tbl[4]  = '{DK, S3, 8, 1, 0, 16'h3216};
        tbl[5]  = '{DT, 7'h55, 8, 1, 1, 16'h3216};
        tbl[6]  = '{4'b0011, S1, 8, 1, 2, 16'h3216};
        tbl[7]  = '{4'b1111, 7'h55, 8, 1, 2, 16'h3216};
        tbl[8]  = '{DU, S5, 8, 1, 2, 16'h3216};
        tbl[9]  = '{DU, S9, 8, 1, 2, 16'h3216};
        tbl[10] = '{DH, S0, 8, 1, 2, 16'h3216};
        tbl[11] = '{DK, S0, 8, 1, 2, 16'h3216};
        tbl[12] = '{DT, S0, 8, 2, 2, 16'h0009};
        vcnt = 0; ecnt = 0;
        for (int i = 0; i < 13; i++) begin
            hold(tbl[i].dig, tbl[i].seg, tbl[i].n);
            chk($sformatf("tbl%0d_vcnt", i), 32'(vcnt), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_ecnt", i), 32'(ecnt), 32'(tbl[i].ee));
            chk($sformatf("tbl%0d_bcd", i), 32'(bcd_o), 32'(tbl[i].eb));
        end

        // Reset mid-frame discards the partial frame
        vcnt = 0; ecnt = 0;
        hold(DU, S1, 8);
        hold(DT, S2, 8);
        hold(DH, S3, 8);
        digit_i = 4'b1111; segment_i = 7'h7F;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_bcd", 32'(bcd_o), 32'h0);
        hold(DK, S4, 8);
        chk("rst_no_valid", 32'(vcnt), 32'd0);
        chk("rst_bcd_hold", 32'(bcd_o), 32'h0);
        hold(DU, S1, 8);
        hold(DT, S2, 8);
        hold(DH, S3, 8);
        chk("rst_frame_vcnt", 32'(vcnt), 32'd1);
        chk("rst_frame_bcd", 32'(bcd_o), 32'h4321);
        chk("rst_frame_ecnt", 32'(ecnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
